// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds and flush
//
// Ports:
//    clk         rising-edge clock for all state
//    reset       asynchronous active-low reset
//    push        write request, data_in sampled with it
//    data_in     write data [WIDTH]
//    pop         read request
//    flush       synchronous clear of pointers and count, overrides push/pop
//    data_out    registered read data [WIDTH], updates after an accepted pop
//    fifo_full   count == DEPTH
//    fifo_empty  count == 0
//    fifo_afull  count >= AFULL_TH
//    fifo_aempty count <= AEMPTY_TH
//    count       current occupancy [CW]
//    overflow    sticky, push rejected while full     (only with FIFO_ERR_EN)
//    underflow   sticky, pop rejected while empty     (only with FIFO_ERR_EN)
//
// Build option: define FIFO_ERR_EN to add the overflow/underflow ports and sticky flags.
module fifo_sync_param #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 4,
   parameter int AFULL_TH  = DEPTH - 1,
   parameter int AEMPTY_TH = 1,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] data_out,
   output logic             fifo_full,
   output logic             fifo_empty,
   output logic             fifo_afull,
   output logic             fifo_aempty,
   output logic [CW-1:0]    count
`ifdef FIFO_ERR_EN
   ,
   output logic             overflow,
   output logic             underflow
`endif
);
   localparam int PW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wp, rp;
   logic             do_push, do_pop;
   assign fifo_full   = count == CW'(DEPTH);
   assign fifo_empty  = count == '0;
   assign fifo_afull  = count >= CW'(AFULL_TH);
   assign fifo_aempty = count <= CW'(AEMPTY_TH);
   // a push into a full FIFO still succeeds when the same-cycle pop frees the slot
   always_comb begin
      do_pop  = pop & ~flush & ~fifo_empty;
      do_push = push & ~flush & (~fifo_full | do_pop);
   end
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= data_in;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wp       <= '0;
         rp       <= '0;
         count    <= '0;
         data_out <= '0;
      end else if (flush) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
         if (do_pop) begin
            rp       <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
            data_out <= mem[rp];
         end
         if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
      end
`ifdef FIFO_ERR_EN
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push & ~flush & ~do_push) overflow <= 1'b1;
         if (pop & ~flush & fifo_empty) underflow <= 1'b1;
      end
`endif
endmodule
